mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (fetch port) and the MEM stage (data port, driven by ControlUnit MemRead/MemWrite).
- Serialises accesses, drives the memory for MEM_LAT cycles per access and returns read data with a one-cycle valid pulse.
- Produces per-port stall signals for the hazard/stall logic.
- Data port wins simultaneous requests; a port is never granted twice in a row while the other waits, so fetch cannot starve.

Parameters:
ADDR_W, 32, byte address width.
DATA_W, 32, data width.
MEM_LAT, 2, memory access cycles per transaction (>=1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request; held high until if_valid.
if_addr  in  ADDR_W  fetch address (PC).
if_kill  in  1  discard the in-flight fetch (taken branch/jump).
if_rdata  out  DATA_W  fetched instruction, registered.
if_valid  out  1  one-cycle completion pulse, fetch port.
if_stall  out  1  if_req & ~if_valid.
dm_req  in  1  data request (MemRead|MemWrite); held high until dm_valid.
dm_we  in  1  1 = store.
dm_addr  in  ADDR_W  data address.
dm_wdata  in  DATA_W  store data.
dm_size  in  3  funct3 of the load/store, forwarded unchanged.
dm_rdata  out  DATA_W  load data, registered.
dm_valid  out  1  one-cycle completion pulse, data port.
dm_stall  out  1  dm_req & ~dm_valid.
mem_en  out  1  memory access enable.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_size  out  3  access size/sign (funct3; 3'b010 for fetch).
mem_rdata  in  DATA_W  memory read data, valid on the last access cycle.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all mem_* = 0; if_valid = dm_valid = 0; if_rdata = dm_rdata = 0; counter = 0; kill flag = 0.
- States: IDLE, WAIT, RESP. Owner register records IF or DM.
- IDLE: at each edge, if dm_req, grant DM; else if if_req, grant IF. On grant, latch addr/we/wdata/size into issue registers, load counter = MEM_LAT and go to WAIT. With no request, stay in IDLE.
- WAIT: mem_en = 1, all mem_* driven from issue registers. mem_we = 1 only for DM stores. Counter decrements each cycle.
  - On the edge with counter == 1: reads capture mem_rdata into the owner's rdata register; go to RESP.
  - Exception: if the owner is IF and the kill flag is set, go to IDLE with no capture and no valid.
- Kill: if_kill sampled high in any WAIT cycle with owner IF sets the kill flag. The flag clears on leaving WAIT. if_kill is ignored otherwise.
- RESP (exactly one cycle): owner's valid = 1. mem_en = 0.
  - Arbitrate with the owner excluded, since its req is still high for the completed access.
  - If the other port requests, grant it and go to WAIT; else go to IDLE.
- Latency: request sampled at edge 0 -> mem_en high cycles 1..MEM_LAT -> valid in cycle MEM_LAT+1. Peak throughput is one access per MEM_LAT+1 cycles.
- Stores: dm_valid pulses on completion; dm_rdata is unchanged. The fetch port never writes.
- rdata registers hold their value until the next capture for the same port.
- Request inputs are sampled only at the grant edge. Changes while waiting are ignored until the next grant.
- Reset mid-access: mem_en and mem_we drop immediately. The access is abandoned and no valid is produced.

Test Plan:
- MEM_LAT=2, if_req=1, if_addr=0x10, mem_rdata=0x00A00093 -> mem_en/mem_addr=0x10 in cycles 1-2, mem_we=0; if_valid in cycle 3 with if_rdata=0x00A00093; if_stall high in cycles 0-2.
- if_req and dm_req (load, addr 0x40, size 3'b010) both raised in cycle 0 -> DM served first, dm_valid in cycle 3; fetch mem_en in cycles 4-5, if_valid in cycle 6; if_stall high in cycles 0-5.
- Store dm_we=1, dm_addr=0x80, dm_wdata=0xDEADBEEF, dm_size=3'b010 -> mem_we=1 for exactly 2 cycles with those values; dm_valid pulse in cycle 3; dm_rdata unchanged.
- dm_req held continuously (new load each completion) with if_req high -> grants alternate DM, IF, DM, IF; no port is granted twice consecutively while the other waits.
- Fetch 0x10 issued, if_kill=1 in cycle 1, new if_addr=0x200 -> no if_valid for 0x10; IDLE in cycle 3; 0x200 issued with mem_en in cycles 4-5.
- rst low in cycle 1 of a store -> mem_en, mem_we, valids and rdata are 0 in the same cycle; after release, busy=0 and no dm_valid appears until a fresh request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported instruction/data memory between the fetch
// port and the data port; the data port wins ties, but neither port is granted twice in a row while the other waits.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_size,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_size_q, mem_size_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              grant_if, grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dm_req) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (owner_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    kill_d      = 1'b0;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_size_d  = '0;
                    // A kill seen in the final cycle still suppresses the response.
                    if (owner_q == OWN_IF && (kill_q || if_kill)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                        if (owner_q == OWN_DM) begin
                            dm_valid_d = 1'b1;
                            if (!mem_we_q) begin
                                dm_rdata_d = mem_rdata;
                            end
                        end else begin
                            if_valid_d = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            S_RESP: begin
                // The owner's req is still up for the access just completed.
                if (owner_q == OWN_DM && if_req) begin
                    grant_if = 1'b1;
                end else if (owner_q == OWN_IF && dm_req) begin
                    grant_dm = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant_dm) begin
            state_d     = S_WAIT;
            owner_d     = OWN_DM;
            cnt_d       = CNT_W'(MEM_LAT);
            kill_d      = 1'b0;
            mem_en_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_size_d  = dm_size;
        end else if (grant_if) begin
            state_d     = S_WAIT;
            owner_d     = OWN_IF;
            cnt_d       = CNT_W'(MEM_LAT);
            kill_d      = 1'b0;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_size_d  = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign dm_stall  = dm_req & ~dm_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory
// accesses and responses, negedge monitors pop and compare them.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst;
    logic        if_req, if_kill;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [2:0]  dm_size;
    logic [31:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  size;
        int          cyc;
    } acc_t;
    resp_t resp_q[$];
    acc_t  acc_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents, fixed per address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h10:  mem_model = 32'h00A00093;
            32'h14:  mem_model = 32'h00500113;
            32'h18:  mem_model = 32'h00B00193;
            32'h1C:  mem_model = 32'h00C00213;
            32'h40:  mem_model = 32'h11223344;
            32'h44:  mem_model = 32'h55667788;
            32'h48:  mem_model = 32'h99AABBCC;
            32'h200: mem_model = 32'h0000006F;
            default: mem_model = 32'hBAD0BAD0;
        endcase
    endfunction
    assign mem_rdata = mem_model(mem_addr);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic exp_acc(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [2:0] sz, input int c);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.size = sz; e.cyc = c;
        acc_q.push_back(e);
    endtask

    task automatic exp_resp(input logic port, input logic [31:0] d, input int c);
        resp_t e;
        e.port = port; e.data = d; e.cyc = c;
        resp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst && (if_valid || dm_valid)) begin
            if (resp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got if_valid=%0b dm_valid=%0b required none (cycle %0d)",
                         if_valid, dm_valid, cyc);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("resp_both_valid", {63'd0, if_valid & dm_valid}, 64'd0);
                chk("resp_port", {63'd0, dm_valid}, {63'd0, e.port});
                chk("resp_data", {32'd0, (dm_valid ? dm_rdata : if_rdata)}, {32'd0, e.data});
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                $display("resp port=%s data=0x%08h cycle=%0d", dm_valid ? "DM" : "IF",
                         dm_valid ? dm_rdata : if_rdata, cyc);
            end
        end
    end

    // Memory-bus monitor
    always @(negedge clk) begin
        if (rst && mem_en) begin
            if (acc_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_mem_en: got addr=0x%0h required no access (cycle %0d)",
                         mem_addr, cyc);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                chk("mem_we", {63'd0, mem_we}, {63'd0, e.we});
                chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
                chk("mem_size", {61'd0, mem_size}, {61'd0, e.size});
                chk("mem_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst = 1'b1;
        if_req = 0; if_kill = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_size = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_valids", {62'd0, if_valid, dm_valid}, 64'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        step(); step();
        rst = 1'b1;

        // Single fetch
        step();
        t0 = cyc;
        if_req = 1; if_addr = 32'h10;
        exp_acc(32'h10, 0, 0, 3'b010, t0 + 1);
        exp_acc(32'h10, 0, 0, 3'b010, t0 + 2);
        exp_resp(1'b0, 32'h00A00093, t0 + 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_if_stall", {63'd0, if_stall}, {63'd0, (k < 3)});
            step();
        end
        if_req = 0;

        // Simultaneous requests: data port first
        step();
        t0 = cyc;
        if_req = 1; if_addr = 32'h14;
        dm_req = 1; dm_we = 0; dm_addr = 32'h40; dm_size = 3'b010;
        exp_acc(32'h40, 0, 0, 3'b010, t0 + 1);
        exp_acc(32'h40, 0, 0, 3'b010, t0 + 2);
        exp_acc(32'h14, 0, 0, 3'b010, t0 + 4);
        exp_acc(32'h14, 0, 0, 3'b010, t0 + 5);
        exp_resp(1'b1, 32'h11223344, t0 + 3);
        exp_resp(1'b0, 32'h00500113, t0 + 6);
        for (int k = 0; k < 7; k++) begin
            if (k == 4) dm_req = 0;
            @(negedge clk);
            chk("t2_if_stall", {63'd0, if_stall}, {63'd0, (k < 6)});
            chk("t2_dm_stall", {63'd0, dm_stall}, {63'd0, (k < 3)});
            step();
        end
        if_req = 0;

        // Store: dm_rdata keeps the previous load value
        step();
        t0 = cyc;
        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF; dm_size = 3'b010;
        exp_acc(32'h80, 1, 32'hDEADBEEF, 3'b010, t0 + 1);
        exp_acc(32'h80, 1, 32'hDEADBEEF, 3'b010, t0 + 2);
        exp_resp(1'b1, 32'h11223344, t0 + 3);
        for (int k = 0; k < 4; k++) step();
        dm_req = 0; dm_we = 0; dm_wdata = 0;

        // Continuous demand on both ports alternates grants
        step();
        t0 = cyc;
        dm_req = 1; dm_addr = 32'h44; if_req = 1; if_addr = 32'h18;
        exp_acc(32'h44, 0, 0, 3'b010, t0 + 1);
        exp_acc(32'h44, 0, 0, 3'b010, t0 + 2);
        exp_acc(32'h18, 0, 0, 3'b010, t0 + 4);
        exp_acc(32'h18, 0, 0, 3'b010, t0 + 5);
        exp_acc(32'h48, 0, 0, 3'b010, t0 + 7);
        exp_acc(32'h48, 0, 0, 3'b010, t0 + 8);
        exp_acc(32'h1C, 0, 0, 3'b010, t0 + 10);
        exp_acc(32'h1C, 0, 0, 3'b010, t0 + 11);
        exp_resp(1'b1, 32'h55667788, t0 + 3);
        exp_resp(1'b0, 32'h00B00193, t0 + 6);
        exp_resp(1'b1, 32'h99AABBCC, t0 + 9);
        exp_resp(1'b0, 32'h00C00213, t0 + 12);
        for (int k = 0; k < 13; k++) begin
            if (k == 4) dm_addr = 32'h48;
            if (k == 7) if_addr = 32'h1C;
            if (k == 10) dm_req = 0;
            step();
        end
        if_req = 0;

        // Killed fetch is dropped, redirected fetch follows
        step();
        t0 = cyc;
        if_req = 1; if_addr = 32'h10;
        exp_acc(32'h10, 0, 0, 3'b010, t0 + 1);
        exp_acc(32'h10, 0, 0, 3'b010, t0 + 2);
        exp_acc(32'h200, 0, 0, 3'b010, t0 + 4);
        exp_acc(32'h200, 0, 0, 3'b010, t0 + 5);
        exp_resp(1'b0, 32'h0000006F, t0 + 6);
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin if_kill = 1; if_addr = 32'h200; end
            if (k == 2) if_kill = 0;
            @(negedge clk);
            if (k == 3) chk("t5_busy_idle", {63'd0, busy}, 64'd0);
            if (k == 3) chk("t5_if_stall", {63'd0, if_stall}, 64'd1);
            step();
        end
        if_req = 0;

        // Reset in the middle of a store
        step();
        dm_req = 1; dm_we = 1; dm_addr = 32'h84; dm_wdata = 32'h12345678; dm_size = 3'b010;
        step();
        #2;
        rst = 0;
        dm_req = 0; dm_we = 0;
        #1;
        chk("t6_mem_en", {63'd0, mem_en}, 64'd0);
        chk("t6_mem_we", {63'd0, mem_we}, 64'd0);
        chk("t6_valids", {62'd0, if_valid, dm_valid}, 64'd0);
        chk("t6_rdata", {if_rdata, dm_rdata}, 64'd0);
        step(); step();
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_busy", {63'd0, busy}, 64'd0);
            chk("t6_dm_valid", {63'd0, dm_valid}, 64'd0);
            step();
        end

        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        chk("acc_queue_drained", 64'(acc_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
